// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle adding-machine controller.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_ERR
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    // Opcodes 000..011 touch memory in EXEC and wait for mem_ready there.
    function automatic logic is_mem_op(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts memory wait cycles and flags a bus timeout when the limit is reached.
// A limit of zero disables the timeout so the controller waits forever.
module mc_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic timeout
);

    localparam int WW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WW-1:0] WAIT_LIMIT = WW'(MEM_WAIT_MAX);

    logic [WW-1:0] wait_cnt;

    // Count stalled memory cycles, restart on every state change, stop at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count_en && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign timeout = (MEM_WAIT_MAX != 0) && count_en && (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC controller for the IR/ACC/PC datapath with
// memory ready handshake, wait timeout trap, halt/restart and retire counter.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OPC_W        = 3,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic             acc_zero,
    input  logic             mem_ready,
    output logic             load_ir,
    output logic             load_acc,
    output logic             ld_pc,
    output logic             clr_pc,
    output logic             inc_pc,
    output logic [1:0]       alu_op,
    output logic             ir_on_adr,
    output logic             pc_on_adr,
    output logic             mem_read,
    output logic             mem_write,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t     state;
    state_t     next_state;
    logic [2:0] op3;
    logic       illegal_op;
    logic       waiting;
    logic       timeout;
    logic       retire;

    assign op3 = opcode[2:0];

    if (OPC_W > 3) begin : g_wide_opc
        assign illegal_op = |opcode[OPC_W-1:3];
    end else begin : g_narrow_opc
        assign illegal_op = 1'b0;
    end

    assign waiting = (state == ST_FETCH) || ((state == ST_EXEC) && is_mem_op(op3));
    assign retire  = (state == ST_EXEC) && ((next_state == ST_FETCH) || (next_state == ST_HALT));

    mc_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .count_en(waiting && !mem_ready),
        .clear   (next_state != state),
        .timeout (timeout)
    );

    // Next-state decision; a ready on the timeout cycle still completes the access.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)    next_state = ST_DECODE;
                else if (timeout) next_state = ST_ERR;
            end
            ST_DECODE: next_state = illegal_op ? ST_ERR : ST_EXEC;
            ST_EXEC: begin
                if (op3 == OP_HALT) begin
                    next_state = ST_HALT;
                end else if (!is_mem_op(op3) || mem_ready) begin
                    next_state = ST_FETCH;
                end else if (timeout) begin
                    next_state = ST_ERR;
                end
            end
            ST_HALT:   if (start) next_state = ST_FETCH;
            ST_ERR:    next_state = ST_ERR;
            default:   next_state = ST_IDLE;
        endcase
    end

    // State register plus saturating count of retired instructions.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            if (retire && (instr_cnt != {CNT_W{1'b1}})) begin
                instr_cnt <= instr_cnt + CNT_W'(1);
            end
        end
    end

    // Datapath and memory strobes decoded from the current state and handshake.
    always_comb begin
        load_ir   = 1'b0;
        load_acc  = 1'b0;
        ld_pc     = 1'b0;
        clr_pc    = 1'b0;
        inc_pc    = 1'b0;
        alu_op    = ALU_PASS;
        ir_on_adr = 1'b0;
        pc_on_adr = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        halted    = 1'b0;
        bus_err   = 1'b0;
        case (state)
            ST_IDLE:   clr_pc = 1'b1;
            ST_FETCH: begin
                pc_on_adr = 1'b1;
                mem_read  = 1'b1;
                load_ir   = mem_ready;
                inc_pc    = mem_ready;
            end
            ST_DECODE: ir_on_adr = 1'b1;
            ST_EXEC: begin
                case (op3)
                    OP_ADD, OP_LOAD, OP_SUB: begin
                        ir_on_adr = 1'b1;
                        mem_read  = 1'b1;
                        load_acc  = mem_ready;
                        alu_op    = (op3 == OP_ADD) ? ALU_ADD :
                                    (op3 == OP_SUB) ? ALU_SUB : ALU_PASS;
                    end
                    OP_STORE: begin
                        ir_on_adr = 1'b1;
                        mem_write = 1'b1;
                    end
                    OP_JMP:  ld_pc = 1'b1;
                    OP_JZ:   ld_pc = acc_zero;
                    default: ;
                endcase
            end
            ST_HALT:   halted  = 1'b1;
            ST_ERR:    bus_err = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: a default-parameter
// instance (A) and a narrow-counter, short-timeout, 4-bit-opcode instance (B).
module tb_multicycle_ctrl;

    // Strobe vector layout:
    // {load_ir, load_acc, ld_pc, clr_pc, inc_pc, alu_op[1:0], ir_on_adr, pc_on_adr, mem_read, mem_write, halted, bus_err}
    localparam logic [15:0] EXP_NONE       = 16'h0000;
    localparam logic [15:0] EXP_IDLE       = 16'h0200;
    localparam logic [15:0] EXP_FETCH_WAIT = 16'h0018;
    localparam logic [15:0] EXP_FETCH_DONE = 16'h1118;
    localparam logic [15:0] EXP_DECODE     = 16'h0020;
    localparam logic [15:0] EXP_LOAD       = 16'h0828;
    localparam logic [15:0] EXP_ADD        = 16'h0868;
    localparam logic [15:0] EXP_SUB        = 16'h08A8;
    localparam logic [15:0] EXP_STORE      = 16'h0024;
    localparam logic [15:0] EXP_LD_PC      = 16'h0400;
    localparam logic [15:0] EXP_HALTED     = 16'h0002;
    localparam logic [15:0] EXP_ERR        = 16'h0001;

    logic clock;
    int   checks;
    int   errors;

    logic        reset_a, start_a, acc_zero_a, mem_ready_a;
    logic [2:0]  opcode_a;
    logic        load_ir_a, load_acc_a, ld_pc_a, clr_pc_a, inc_pc_a;
    logic [1:0]  alu_op_a;
    logic        ir_on_adr_a, pc_on_adr_a, mem_read_a, mem_write_a, halted_a, bus_err_a;
    logic [15:0] instr_cnt_a;

    logic        reset_b, start_b, acc_zero_b, mem_ready_b;
    logic [3:0]  opcode_b;
    logic        load_ir_b, load_acc_b, ld_pc_b, clr_pc_b, inc_pc_b;
    logic [1:0]  alu_op_b;
    logic        ir_on_adr_b, pc_on_adr_b, mem_read_b, mem_write_b, halted_b, bus_err_b;
    logic [1:0]  instr_cnt_b;

    logic [15:0] strobes_a;
    logic [15:0] strobes_b;

    assign strobes_a = {3'b000, load_ir_a, load_acc_a, ld_pc_a, clr_pc_a, inc_pc_a, alu_op_a,
                        ir_on_adr_a, pc_on_adr_a, mem_read_a, mem_write_a, halted_a, bus_err_a};
    assign strobes_b = {3'b000, load_ir_b, load_acc_b, ld_pc_b, clr_pc_b, inc_pc_b, alu_op_b,
                        ir_on_adr_b, pc_on_adr_b, mem_read_b, mem_write_b, halted_b, bus_err_b};

    multicycle_ctrl dut_a (
        .clock(clock), .reset(reset_a), .start(start_a), .opcode(opcode_a),
        .acc_zero(acc_zero_a), .mem_ready(mem_ready_a),
        .load_ir(load_ir_a), .load_acc(load_acc_a), .ld_pc(ld_pc_a), .clr_pc(clr_pc_a),
        .inc_pc(inc_pc_a), .alu_op(alu_op_a), .ir_on_adr(ir_on_adr_a), .pc_on_adr(pc_on_adr_a),
        .mem_read(mem_read_a), .mem_write(mem_write_a), .halted(halted_a), .bus_err(bus_err_a),
        .instr_cnt(instr_cnt_a)
    );

    multicycle_ctrl #(.OPC_W(4), .MEM_WAIT_MAX(4), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b), .opcode(opcode_b),
        .acc_zero(acc_zero_b), .mem_ready(mem_ready_b),
        .load_ir(load_ir_b), .load_acc(load_acc_b), .ld_pc(ld_pc_b), .clr_pc(clr_pc_b),
        .inc_pc(inc_pc_b), .alu_op(alu_op_b), .ir_on_adr(ir_on_adr_b), .pc_on_adr(pc_on_adr_b),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .halted(halted_b), .bus_err(bus_err_b),
        .instr_cnt(instr_cnt_b)
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs on the falling edge, then settle before checking.
    task automatic applyStimulus(input bit sel_b, input logic st, input logic [3:0] op,
                                 input logic az, input logic rdy);
        @(negedge clock);
        if (sel_b) begin
            start_b = st; opcode_b = op; acc_zero_b = az; mem_ready_b = rdy;
        end else begin
            start_a = st; opcode_a = op[2:0]; acc_zero_a = az; mem_ready_a = rdy;
        end
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input bit sel_b, input logic [15:0] exp);
        checkValue(tag, sel_b ? strobes_b : strobes_a, exp);
    endtask

    task automatic checkCount(input string tag, input bit sel_b, input logic [15:0] exp);
        checkValue(tag, sel_b ? {14'd0, instr_cnt_b} : instr_cnt_a, exp);
    endtask

    // One full instruction with memory always ready: FETCH, DECODE, EXEC.
    task automatic runInstr(input bit sel_b, input logic [3:0] op, input logic az,
                            input logic [15:0] exp_exec, input logic [15:0] exp_cnt,
                            input string tag);
        applyStimulus(sel_b, 1'b0, op, az, 1'b1);
        checkOutput($sformatf("%s_fetch", tag), sel_b, EXP_FETCH_DONE);
        checkCount($sformatf("%s_cnt", tag), sel_b, exp_cnt);
        applyStimulus(sel_b, 1'b0, op, az, 1'b1);
        checkOutput($sformatf("%s_decode", tag), sel_b, EXP_DECODE);
        applyStimulus(sel_b, 1'b0, op, az, 1'b1);
        checkOutput($sformatf("%s_exec", tag), sel_b, exp_exec);
    endtask

    // Directed sequence: instance A first, then instance B.
    initial begin
        checks = 0;
        errors = 0;
        reset_a = 1'b1; start_a = 1'b0; opcode_a = 3'b0; acc_zero_a = 1'b0; mem_ready_a = 1'b1;
        reset_b = 1'b1; start_b = 1'b0; opcode_b = 4'b0; acc_zero_b = 1'b0; mem_ready_b = 1'b1;

        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("a_reset_strobes", 1'b0, EXP_IDLE);
        checkCount("a_reset_cnt", 1'b0, 16'd0);
        @(negedge clock);
        reset_a = 1'b0;

        // LOAD, ADD, STORE, HALT at 3 cycles each
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        checkOutput("a_idle_start", 1'b0, EXP_IDLE);
        runInstr(1'b0, 4'b0001, 1'b0, EXP_LOAD,  16'd0, "a_load");
        runInstr(1'b0, 4'b0000, 1'b0, EXP_ADD,   16'd1, "a_add");
        runInstr(1'b0, 4'b0010, 1'b0, EXP_STORE, 16'd2, "a_store");
        runInstr(1'b0, 4'b0111, 1'b0, EXP_NONE,  16'd3, "a_halt");
        applyStimulus(1'b0, 1'b0, 4'h7, 1'b0, 1'b1);
        checkOutput("a_halted", 1'b0, EXP_HALTED);
        checkCount("a_cnt_after_halt", 1'b0, 16'd4);

        // Restart from HALT without clearing PC, then stall FETCH for 3 cycles
        applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
        checkOutput("a_halt_restart", 1'b0, EXP_HALTED);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0101, 1'b1, 1'b0);
            checkOutput($sformatf("a_fetch_wait%0d", i), 1'b0, EXP_FETCH_WAIT);
        end
        applyStimulus(1'b0, 1'b0, 4'b0101, 1'b1, 1'b1);
        checkOutput("a_fetch_ready", 1'b0, EXP_FETCH_DONE);
        applyStimulus(1'b0, 1'b1, 4'b0101, 1'b1, 1'b1);
        checkOutput("a_decode_start_ignored", 1'b0, EXP_DECODE);
        applyStimulus(1'b0, 1'b0, 4'b0101, 1'b1, 1'b1);
        checkOutput("a_jz_taken", 1'b0, EXP_LD_PC);

        runInstr(1'b0, 4'b0101, 1'b0, EXP_NONE,  16'd5, "a_jz_not_taken");
        runInstr(1'b0, 4'b0011, 1'b0, EXP_SUB,   16'd6, "a_sub");
        runInstr(1'b0, 4'b0100, 1'b0, EXP_LD_PC, 16'd7, "a_jmp");
        runInstr(1'b0, 4'b0110, 1'b0, EXP_NONE,  16'd8, "a_nop");

        // Reset in the middle of a stalled FETCH
        applyStimulus(1'b0, 1'b0, 4'b0110, 1'b0, 1'b0);
        checkOutput("a_fetch_stall", 1'b0, EXP_FETCH_WAIT);
        checkCount("a_cnt_before_reset", 1'b0, 16'd9);
        #2 reset_a = 1'b1;
        #1;
        checkOutput("a_async_reset_strobes", 1'b0, EXP_IDLE);
        checkCount("a_async_reset_cnt", 1'b0, 16'd0);
        @(negedge clock);
        reset_a = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("a_idle_needs_start", 1'b0, EXP_IDLE);
        applyStimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        checkOutput("a_idle_start2", 1'b0, EXP_IDLE);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("a_fetch_after_reset", 1'b0, EXP_FETCH_DONE);

        // Instance B: counter saturation, store timeout, illegal opcode
        @(negedge clock);
        reset_b = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'h0, 1'b0, 1'b1);
        checkOutput("b_idle_start", 1'b1, EXP_IDLE);
        runInstr(1'b1, 4'b0110, 1'b0, EXP_NONE, 16'd0, "b_nop0");
        runInstr(1'b1, 4'b0110, 1'b0, EXP_NONE, 16'd1, "b_nop1");
        runInstr(1'b1, 4'b0110, 1'b0, EXP_NONE, 16'd2, "b_nop2");
        runInstr(1'b1, 4'b0110, 1'b0, EXP_NONE, 16'd3, "b_nop3");
        runInstr(1'b1, 4'b0110, 1'b0, EXP_NONE, 16'd3, "b_nop_sat");

        applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);
        checkOutput("b_store_fetch", 1'b1, EXP_FETCH_DONE);
        checkCount("b_cnt_saturated", 1'b1, 16'd3);
        applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);
        checkOutput("b_store_decode", 1'b1, EXP_DECODE);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
            checkOutput($sformatf("b_store_wait%0d", i), 1'b1, EXP_STORE);
        end
        applyStimulus(1'b1, 1'b1, 4'b0010, 1'b0, 1'b0);
        checkOutput("b_timeout_err", 1'b1, EXP_ERR);
        applyStimulus(1'b1, 1'b0, 4'b0010, 1'b0, 1'b1);
        checkOutput("b_err_start_ignored", 1'b1, EXP_ERR);

        #2 reset_b = 1'b1;
        #1;
        checkOutput("b_reset_clears_err", 1'b1, EXP_IDLE);
        checkCount("b_reset_cnt", 1'b1, 16'd0);
        @(negedge clock);
        reset_b = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'b1000, 1'b0, 1'b1);
        checkOutput("b_idle_start2", 1'b1, EXP_IDLE);
        applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
        checkOutput("b_illegal_fetch", 1'b1, EXP_FETCH_DONE);
        applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
        checkOutput("b_illegal_decode", 1'b1, EXP_DECODE);
        applyStimulus(1'b1, 1'b0, 4'b1000, 1'b0, 1'b1);
        checkOutput("b_illegal_err", 1'b1, EXP_ERR);
        checkCount("b_illegal_cnt", 1'b1, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
